// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the packet-aware weighted round-robin arbiter.
package arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Index width for an N-entry selector; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_mask_select.sv
// Round-robin first-set search: finds the first request at or above ptr,
// wrapping back to bit 0. The request vector is duplicated so that the
// wrapped search becomes a single lowest-index priority encode.
module rr_mask_select
   import arbiter_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] masked;

   assign req2 = {req, req};

   // Lower copy keeps only bits at or above ptr; upper copy supplies the wrap.
   for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
      if (gi >= N) begin : g_upper
         assign masked[gi] = req2[gi];
      end else begin : g_lower
         assign masked[gi] = req2[gi] & (gi >= int'(ptr));
      end
   end

   // Lowest set bit of the masked double-width vector wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (masked[i]) begin
            found = 1'b1;
            idx   = IW'(i % N);
         end
      end
   end

endmodule

// File: rtl/arbiter_wrr_packet.sv
// Packet-locked weighted round-robin arbiter with a registered output slot.
// A grantee keeps the output for a whole packet and may send up to
// max(cfg_weight,1) packets per turn before priority rotates.
// Optional idle watchdog on the grantee: define ARB_WATCHDOG_EN.
module arbiter_wrr_packet
   import arbiter_pkg::*;
#(
   parameter int DWIDTH   = 20,
   parameter int N        = 2,
   parameter int WEIGHT_W = 4,
   parameter int TIMEOUT  = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid   [N-1:0],
   input  logic [DWIDTH-1:0]      in_data    [N-1:0],
   input  logic                   in_last    [N-1:0],
   output logic                   in_ready   [N-1:0],
   input  logic [WEIGHT_W-1:0]    cfg_weight [N-1:0],
   output logic                   out_valid,
   output logic [DWIDTH-1:0]      out_data,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic [idx_w(N)-1:0]    grant_idx,
   output logic                   busy
`ifdef ARB_WATCHDOG_EN
   ,
   output logic                   err_timeout
`endif
);

   localparam int IW = idx_w(N);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [WEIGHT_W-1:0] credit_q, credit_d;
   logic                out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;

   logic [N-1:0]        req_vec;
   logic                sel_found;
   logic [IW-1:0]       sel_idx;
   logic [WEIGHT_W-1:0] sel_weight;
   logic                load_en;
   logic                g_valid;
   logic                g_last;
   logic                accept;
   logic [IW-1:0]       next_ptr;
   logic                wd_fire;

   for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign req_vec[gi]  = in_valid[gi];
      // Only the locked grantee sees ready, and only when the slot can load.
      assign in_ready[gi] = (state_q == LOCKED) && (grant_q == IW'(gi)) && load_en;
   end

   rr_mask_select #(.N(N)) u_sel (
      .req   (req_vec),
      .ptr   (ptr_q),
      .found (sel_found),
      .idx   (sel_idx)
   );

   assign load_en    = ~out_valid_q | out_ready;
   assign g_valid    = in_valid[grant_q];
   assign g_last     = in_last[grant_q];
   assign accept     = (state_q == LOCKED) && g_valid && load_en;
   assign next_ptr   = (grant_q == IW'(N-1)) ? '0 : grant_q + 1'b1;
   assign sel_weight = (cfg_weight[sel_idx] == '0) ? WEIGHT_W'(1) : cfg_weight[sel_idx];

`ifdef ARB_WATCHDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] wd_cnt_q, wd_cnt_d;
   logic          err_q;

   assign wd_fire = (state_q == LOCKED) && !g_valid && (wd_cnt_q == CW'(TIMEOUT - 1));

   // Count locked cycles where the grantee has nothing to offer.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q != LOCKED || accept || wd_fire) begin
         wd_cnt_d = '0;
      end else if (!g_valid) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
      end
   end

   // Watchdog counter and one-cycle error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         err_q    <= wd_fire;
      end
   end

   assign err_timeout = err_q;
`else
   assign wd_fire = 1'b0;
`endif

   // Arbitration FSM: IDLE picks or keeps a grantee, LOCKED holds it to packet end.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      case (state_q)
         IDLE: begin
            if ((credit_q != '0) && g_valid) begin
               state_d = LOCKED;
            end else if (sel_found) begin
               grant_d  = sel_idx;
               credit_d = sel_weight;
               state_d  = LOCKED;
            end
         end
         LOCKED: begin
            if (accept && g_last) begin
               credit_d = credit_q - 1'b1;
               state_d  = IDLE;
               if (credit_q == WEIGHT_W'(1)) begin
                  ptr_d = next_ptr;
               end
            end else if (wd_fire) begin
               credit_d = '0;
               ptr_d    = next_ptr;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output slot: load on accepted beat, drain on downstream ready.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[grant_q];
         out_last_d  = g_last;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State, pointer, credit and output slot registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         credit_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         credit_q    <= credit_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign grant_idx = grant_q;
   assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_arbiter_wrr_packet.sv
// Bench for arbiter_wrr_packet (N=2, TIMEOUT=8). Sources present continuous
// packets; the expected output stream is the packet-level WRR order
// (each source sends max(weight,1) packets per turn, starting at source 0).
// Watchdog section depends on ARB_WATCHDOG_EN.
module tb_arbiter_wrr_packet;

   localparam int DW = 20;
   localparam int NS = 2;
   localparam int MAXP = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid   [NS-1:0];
   logic [DW-1:0] in_data    [NS-1:0];
   logic          in_last    [NS-1:0];
   logic          in_ready   [NS-1:0];
   logic [3:0]    cfg_weight [NS-1:0];
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic [0:0]    grant_idx;
   logic          busy;
`ifdef ARB_WATCHDOG_EN
   logic          err_timeout;
`endif

   arbiter_wrr_packet #(.DWIDTH(DW), .N(NS), .WEIGHT_W(4), .TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .cfg_weight (cfg_weight),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .grant_idx  (grant_idx),
      .busy       (busy)
`ifdef ARB_WATCHDOG_EN
      ,
      .err_timeout(err_timeout)
`endif
   );

   always #5 clk = ~clk;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   int  pkt_i  [NS];
   int  beat_i [NS];
   int  lens   [NS][MAXP];
   bit  en     [NS];
   bit  hold   [NS];
   logic [DW:0] exp_q[$];
   bit  model_on;
   bit  stall_mode;
   int  seen;
   int  rdy_pct;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int s = 0; s < NS; s++) begin
         in_valid[s] = en[s] && !hold[s];
         in_data[s]  = {2'(s), 10'(pkt_i[s]), 8'(beat_i[s])};
         in_last[s]  = (beat_i[s] == lens[s][pkt_i[s] % MAXP] - 1);
      end
   endtask

   // One clock: check at the falling edge, update sources after the rising edge.
   task automatic tick();
      bit fire [NS];
      logic [DW:0] e;
      @(negedge clk);
      if (model_on) begin
         check("one_ready", 32'(in_ready[0] & in_ready[1]), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("beat", 32'({out_last, out_data}), 32'(e));
            end
            seen++;
         end
      end
      for (int s = 0; s < NS; s++) fire[s] = in_valid[s] && in_ready[s];
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
         if (fire[s]) begin
            if (beat_i[s] == lens[s][pkt_i[s] % MAXP] - 1) begin
               beat_i[s] = 0;
               pkt_i[s]++;
            end else begin
               beat_i[s]++;
            end
         end
      end
      if (!stall_mode) out_ready = ($urandom_range(0, 99) < rdy_pct);
      drive();
   endtask

   task automatic apply_reset();
      #2;
      rst = 1'b0;
      stall_mode = 0;
      model_on = 0;
      out_ready = 1'b1;
      for (int s = 0; s < NS; s++) begin
         en[s] = 0; hold[s] = 0; pkt_i[s] = 0; beat_i[s] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Packet-level WRR order: each turn a source sends max(w,1) packets.
   task automatic build_model(input int w0, input int w1);
      int cnt [NS];
      int w, s, npk;
      cnt[0] = 0; cnt[1] = 0; s = 0; npk = 0;
      exp_q.delete();
      while (npk < 200) begin
         w = (s == 0) ? w0 : w1;
         if (w == 0) w = 1;
         for (int j = 0; j < w; j++) begin
            for (int b = 0; b < lens[s][cnt[s]]; b++)
               exp_q.push_back({b == lens[s][cnt[s]] - 1, 2'(s), 10'(cnt[s]), 8'(b)});
            cnt[s]++;
            npk++;
         end
         s = 1 - s;
      end
   endtask

   task automatic do_stall();
      logic        ov;
      logic [DW:0] od;
      stall_mode = 1;
      out_ready  = 1'b0;
      ov = out_valid;
      od = {out_last, out_data};
      repeat (5) begin
         tick();
         if (ov) begin
            check("stall_hold", 32'({out_last, out_data}), 32'(od));
            check("stall_ready", 32'(in_ready[0] | in_ready[1]), 32'd0);
         end
      end
      stall_mode = 0;
   endtask

   task automatic run_phase(input int w0, input int w1, input int lo0, input int hi0,
                            input int lo1, input int hi1, input int pct, input int target,
                            input int stall_at, input bit lat);
      int cyc;
      apply_reset();
      cfg_weight[0] = 4'(w0);
      cfg_weight[1] = 4'(w1);
      for (int p = 0; p < MAXP; p++) begin
         lens[0][p] = $urandom_range(hi0, lo0);
         lens[1][p] = $urandom_range(hi1, lo1);
      end
      build_model(w0, w1);
      rdy_pct = pct;
      out_ready = 1'b1;
      en[0] = 1; en[1] = 1;
      model_on = 1;
      seen = 0;
      cyc = 0;
      drive();
      if (lat) begin
         tick(); cyc++;
         check("lat_busy", 32'(busy), 32'd1);
         check("lat_ov0", 32'(out_valid), 32'd0);
         tick(); cyc++;
         check("lat_ov1", 32'(out_valid), 32'd1);
         check("lat_src0", 32'(out_data[19:18]), 32'd0);
      end
      while (seen < target && cyc < 3000) begin
         tick();
         cyc++;
         if (cyc == stall_at) do_stall();
      end
      check("phase_beats", 32'(seen), 32'(target));
      model_on = 0;
   endtask

   initial begin
      int cyc;
      int pulses;
      rst = 1'b0;
      out_ready = 1'b1;
      cfg_weight[0] = 4'd1; cfg_weight[1] = 4'd1;
      for (int s = 0; s < NS; s++) begin
         en[s] = 0; hold[s] = 0; pkt_i[s] = 0; beat_i[s] = 0;
         for (int p = 0; p < MAXP; p++) lens[s][p] = 1;
      end
      drive();
      apply_reset();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_grant_idx", 32'(grant_idx), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef ARB_WATCHDOG_EN
      check("rst_err_timeout", 32'(err_timeout), 32'd0);
`endif

      // Equal weights, single-beat packets: strict alternation.
      run_phase(1, 1, 1, 1, 1, 1, 100, 20, 0, 1);
      // Weights 3/1: 0,0,0,1 pattern.
      run_phase(3, 1, 1, 1, 1, 1, 100, 24, 0, 0);
      // 4-beat packets from source 0 against single beats from source 1.
      run_phase(1, 1, 4, 4, 1, 1, 100, 30, 0, 0);
      // Downstream stall in mid-packet.
      run_phase(2, 2, 3, 6, 1, 3, 100, 40, 7, 0);
      // Randomized weights (including 0), lengths and backpressure.
      for (int r = 0; r < 4; r++)
         run_phase($urandom_range(3, 0), $urandom_range(3, 0), 1, 5, 1, 5,
                   $urandom_range(100, 40), 60, 0, 0);

      // Asynchronous reset between clock edges, mid-packet.
      run_phase(1, 1, 4, 4, 4, 4, 100, 10, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_grant", 32'(grant_idx), 32'd0);
      run_phase(2, 1, 1, 4, 1, 2, 70, 40, 0, 0);

      // Grantee goes silent mid-packet.
      apply_reset();
      cfg_weight[0] = 4'd1; cfg_weight[1] = 4'd1;
      for (int p = 0; p < MAXP; p++) begin
         lens[0][p] = 4;
         lens[1][p] = 1;
      end
      rdy_pct = 100;
      en[0] = 1; en[1] = 1;
      drive();
      cyc = 0;
      while (beat_i[0] != 2 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("wd_reach_beat2", 32'(beat_i[0]), 32'd2);
      hold[0] = 1;
      drive();
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
`ifdef ARB_WATCHDOG_EN
         if (err_timeout) pulses++;
`else
         check("wd_busy_hold", 32'(busy), 32'd1);
`endif
      end
`ifdef ARB_WATCHDOG_EN
      check("wd_pulses", 32'(pulses), 32'd1);
      check("wd_regrant", 32'(grant_idx), 32'd1);
`else
      check("wd_grant_kept", 32'(grant_idx), 32'd0);
`endif
      hold[0] = 0;
      drive();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/arbiter_wrr_packet.md
Name: arbiter_wrr_packet

Overview:
Packet-aware weighted round-robin arbiter that shares one valid/ready output stream among N requester streams. A grant is locked for a whole packet, which is delimited by in_last. Each requester may send up to cfg_weight consecutive packets before priority rotates. The output stage is registered and sits between source FIFOs and a single downstream consumer, with the same stream semantics as the fixed-priority arbiters.

Parameters:
- DWIDTH, 20: data width per beat.
- N, 2: number of requesters, ≥1.
- WEIGHT_W, 4: width of each per-requester weight.
- TIMEOUT, 256: idle-cycle limit for the watchdog. Used only with the macro.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1 x [N-1:0] unpacked  per-requester beat valid.
- in_data  in  [DWIDTH-1:0] x [N-1:0] unpacked  per-requester beat data.
- in_last  in  1 x [N-1:0] unpacked  last beat of packet.
- in_ready  out  1 x [N-1:0] unpacked  per-requester accept.
- cfg_weight  in  [WEIGHT_W-1:0] x [N-1:0] unpacked  packets per turn; 0 is treated as 1.
- out_valid  out  1  registered output valid.
- out_data  out  [DWIDTH-1:0]  registered output data.
- out_last  out  1  registered last flag.
- out_ready  in  1  downstream accept.
- grant_idx  out  [$clog2(N) or 1 if N=1]  current/last grantee.
- busy  out  1  high in LOCKED.
- err_timeout  out  1  one-cycle watchdog pulse. Present only with the macro.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_last=0, grant_idx=0, busy=0, err_timeout=0.
  - ptr=0, credit=0, state=IDLE.
  - An in-flight packet is discarded. No partial state survives reset.
- Output slot:
  - load_en = ~out_valid | out_ready.
  - A beat is accepted when in_valid[g] & in_ready[g].
  - Accepting a beat loads out_data/out_last and sets out_valid on the next edge.
  - Without a new beat, out_valid clears when out_ready=1.
  - out_data/out_last are held stable while out_valid & ~out_ready.
- FSM IDLE:
  - in_ready all 0.
  - Stay in the current turn if credit>0 and in_valid[grant_idx]=1: stay with grantee.
  - Otherwise, if any in_valid: rotate. g = first i with in_valid[i], searching from ptr upward mod N. Set credit=max(cfg_weight[g],1).
  - Either case: grant_idx<=g, go to LOCKED.
  - No requests: remain in IDLE.
- FSM LOCKED:
  - in_ready[g] = load_en. All other in_ready = 0.
  - Accepted beat with in_last=1:
    - credit<=credit-1, state<=IDLE.
    - If credit-1==0, ptr<=(g+1) mod N, with wrap N-1→0.
  - Non-granted requesters are never accepted mid-packet, even if the grantee stalls.
- Latency:
  - Registered grant: first beat is accepted 1 cycle after in_valid is seen in IDLE.
  - Beat to out_valid: 1 cycle.
  - Back-to-back packets from the same grantee lose 1 cycle (IDLE) per packet boundary.
- Simultaneous events:
  - A packet-end beat and out_ready in the same cycle: both take effect.
  - When credit runs out, the ptr update is seen by the next IDLE arbitration.
- cfg_weight is sampled only at rotation. Changes mid-turn apply at the next turn.
- N=1: ptr is constant 0 and the weight logic is still exercised.

Optional Feature:
ARB_WATCHDOG_EN
- Defined:
  - A counter counts LOCKED cycles with in_valid[g]=0, and clears on any accepted beat.
  - At count==TIMEOUT-1: pulse err_timeout for 1 cycle, credit<=0, ptr<=(g+1) mod N, state<=IDLE.
  - The output slot is unaffected.
  - The truncated packet is not patched; there is no synthetic out_last.
- Undefined:
  - No counter and no err_timeout port.
  - LOCKED waits indefinitely.

Decomposition:
- Package arbiter_pkg:
  - arb_state_e {IDLE, LOCKED}.
  - Function idx_w(N) returning max($clog2(N),1).
- Sub-module rr_mask_select (combinational, parameter N):
  - Inputs: req vector and ptr.
  - Outputs: found flag and index of the first set bit at or above ptr, wrapping.
  - Implementation: double-width mask, then priority encode.
- Top-level contents: FSM, credit, ptr, output slot and watchdog.

Test Plan:
1. N=2, weights 1/1, both sources send 1-beat packets continuously, out_ready=1 → grant_idx sequence 0,1,0,1, and out_data alternates between sources.
2. N=2, weights 3/1, both continuous 1-beat packets → packet order 0,0,0,1,0,0,0,1.
3. Source 0 sends a 4-beat packet (last on beat 4) while source 1 requests throughout → 4 contiguous beats from 0 with out_last only on beat 4; in_ready[1]=0 until source 0 reaches IDLE, then source 1 is granted.
4. out_ready held 0 for 5 cycles mid-packet → out_data/out_last stable, in_ready[g]=0 during the stall; no beat lost or duplicated (scoreboard count matches).
5. rst driven low mid-packet, asynchronously between edges → out_valid=0 immediately; after release, ptr=0, and with both requesting, grant_idx=0 first.
6. With ARB_WATCHDOG_EN and TIMEOUT=8: grantee drops in_valid mid-packet for 8 cycles → err_timeout pulses exactly once, busy falls, other requester is granted next; without the macro, busy stays 1.
